descrambler_sync_ctrl: RTL and testbench

DESCRAMBLER_SYNC_CTRL -- requirements
Module: descrambler_sync_ctrl

---
 rtl/descrambler_sync_ctrl.sv | 172 +++++++++++++++++
 tb/tb_descrambler_sync_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/descrambler_sync_ctrl.sv
// descrambler_sync_ctrl
//   Frame-sync supervisor for a self-synchronising 58-bit descrambler.
//   It resets (seeds) the descrambler, waits for the LFSR to fill, hunts for
//   LOCK_CNT consecutive frame words carrying SYNC_PATTERN in bits [25:20],
//   then stays LOCKED until UNLOCK_CNT consecutive bad frames, a frame gap
//   of GAP_MAX cycles, or an explicit relock request forces a re-seed.
//
// Ports
//   clk          in   single rising-edge clock
//   rst_n        in   synchronous active-low reset
//   chk_data     in   [25:0] descrambler output word
//   chk_frame    in   chk_data is a frame word when high
//   cfg_bypass   in   bypass request, forwarded to desc_bypass
//   relock_req   in   one-cycle pulse forcing a re-seed
//   err_clr      in   pulse clearing err_cnt and loss_cnt
//   desc_rst     out  active-high descrambler reset
//   desc_bypass  out  registered copy of cfg_bypass
//   locked       out  high exactly while state == LOCKED
//   state        out  [2:0] FSM state (SEED=0 FILL=1 HUNT=2 LOCKED=3)
//   err_cnt      out  [15:0] bad frames seen while LOCKED, saturating
//   loss_cnt     out  [7:0] LOCKED-to-re-seed transitions, saturating
//
// Handshake: there is no backpressure; chk_frame is a plain qualifier and a
// frame word is consumed in every cycle where chk_frame is high.

module descrambler_sync_ctrl #(
  parameter logic [5:0] SYNC_PATTERN = 6'b101100,
  parameter int RST_CYCLES   = 2,
  parameter int FILL_CYCLES  = 4,
  parameter int LOCK_CNT     = 8,
  parameter int UNLOCK_CNT   = 4,
  parameter int HUNT_TIMEOUT = 1024,
  parameter int GAP_MAX      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [25:0] chk_data,
  input  logic        chk_frame,
  input  logic        cfg_bypass,
  input  logic        relock_req,
  input  logic        err_clr,
  output logic        desc_rst,
  output logic        desc_bypass,
  output logic        locked,
  output logic [2:0]  state,
  output logic [15:0] err_cnt,
  output logic [7:0]  loss_cnt
);

  localparam logic [2:0] S_SEED   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_HUNT   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;

  // One shared cycle timer serves every state, so size it for the largest.
  localparam int T_A  = (RST_CYCLES > FILL_CYCLES) ? RST_CYCLES : FILL_CYCLES;
  localparam int T_B  = (HUNT_TIMEOUT > GAP_MAX) ? HUNT_TIMEOUT : GAP_MAX;
  localparam int TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int RMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_CYCLES - 1);
  localparam logic [CW-1:0] HUNT_LAST = CW'(HUNT_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_MAX - 1);
  localparam logic [RW-1:0] LOCK_N    = RW'(LOCK_CNT);
  localparam logic [RW-1:0] UNLOCK_N  = RW'(UNLOCK_CNT);

  logic [2:0]    state_q;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cyc_q;   // cycles in state (HUNT/SEED/FILL) or frame gap (LOCKED)
  logic [RW-1:0] run_q;   // good run in HUNT, bad run in LOCKED
  logic [RW-1:0] run_inc;
  logic          good;
  logic          bad;
  logic          entry;
  logic          desc_rst_nxt;
  logic          locked_nxt;
  logic          err_inc;
  logic          loss_inc;
  logic          unused_data;

  assign unused_data = ^chk_data[19:0];

  assign good    = chk_frame && (chk_data[25:20] == SYNC_PATTERN);
  assign bad     = chk_frame && (chk_data[25:20] != SYNC_PATTERN);
  assign run_inc = run_q + RW'(1);
  assign state   = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_SEED;
    else        state_q <= state_nxt;
  end

  // Next-state logic; relock_req overrides every other decision.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_SEED:   if (cyc_q == RST_LAST) state_nxt = S_FILL;
      S_FILL:   if (cyc_q == FILL_LAST) state_nxt = S_HUNT;
      S_HUNT: begin
        if (good && (run_inc == LOCK_N)) state_nxt = S_LOCKED;
        else if (cyc_q == HUNT_LAST)     state_nxt = S_SEED;
      end
      S_LOCKED: begin
        if (bad && (run_inc == UNLOCK_N))       state_nxt = S_SEED;
        else if (!chk_frame && cyc_q == GAP_LAST) state_nxt = S_SEED;
      end
      default:  state_nxt = S_SEED;
    endcase
    if (relock_req) state_nxt = S_SEED;
  end

  // A relock while already in SEED is a re-entry and restarts the seed.
  assign entry = relock_req || (state_nxt != state_q);

  // Output decode (registered below)
  always_comb begin
    desc_rst_nxt = (state_q == S_SEED);
    locked_nxt   = (state_nxt == S_LOCKED);
    err_inc      = (state_q == S_LOCKED) && bad;
    loss_inc     = (state_q == S_LOCKED) && (state_nxt == S_SEED);
  end

  // Run and timeout counters, cleared on every state entry
  always_ff @(posedge clk) begin
    if (!rst_n || entry) begin
      cyc_q <= '0;
      run_q <= '0;
    end else begin
      case (state_q)
        S_HUNT: begin
          cyc_q <= cyc_q + CW'(1);
          if (good)     run_q <= run_inc;
          else if (bad) run_q <= '0;
        end
        S_LOCKED: begin
          if (chk_frame) cyc_q <= '0;
          else           cyc_q <= cyc_q + CW'(1);
          if (bad)       run_q <= run_inc;
          else if (good) run_q <= '0;
        end
        default: cyc_q <= cyc_q + CW'(1);
      endcase
    end
  end

  // Registered outputs and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      desc_rst    <= 1'b1;
      desc_bypass <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= '0;
      loss_cnt    <= '0;
    end else begin
      desc_rst    <= desc_rst_nxt;
      desc_bypass <= cfg_bypass;
      locked      <= locked_nxt;
      if (err_clr) begin
        err_cnt  <= '0;
        loss_cnt <= '0;
      end else begin
        if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        if (loss_inc && (loss_cnt != 8'hFF))  loss_cnt <= loss_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_descrambler_sync_ctrl.sv
// Directed bench for descrambler_sync_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_descrambler_sync_ctrl;

  localparam logic [5:0] SYNC = 6'b101100;
  localparam logic [5:0] NOSYNC = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] chk_data;
  logic        chk_frame;
  logic        cfg_bypass;
  logic        relock_req;
  logic        err_clr;
  logic        desc_rst;
  logic        desc_bypass;
  logic        locked;
  logic [2:0]  state;
  logic [15:0] err_cnt;
  logic [7:0]  loss_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  descrambler_sync_ctrl dut (
    .clk(clk), .rst_n(rst_n), .chk_data(chk_data), .chk_frame(chk_frame),
    .cfg_bypass(cfg_bypass), .relock_req(relock_req), .err_clr(err_clr),
    .desc_rst(desc_rst), .desc_bypass(desc_bypass), .locked(locked),
    .state(state), .err_cnt(err_cnt), .loss_cnt(loss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0 = good frame word, 1 = bad frame word
  task automatic frame(input logic f, input int kind);
    logic [5:0] hdr;
    hdr = (kind == 0) ? SYNC : NOSYNC;
    chk_frame = f;
    chk_data  = {hdr, 20'($urandom_range(0, 20'hFFFFF))};
  endtask

  // Called on the first sampled cycle of SEED; good frames lock after 14 cycles.
  task automatic lock_up(input string tag);
    frame(1'b1, 0);
    step(1);
    check({tag, "_rst"}, desc_rst, 1);
    step(12);
    check({tag, "_prelock"}, locked, 0);
    step(1);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_state"}, state, 3);
  endtask

  initial begin
    rst_n = 1'b0; cfg_bypass = 1'b0; relock_req = 1'b0; err_clr = 1'b0;
    frame(1'b0, 0);
    step(3);
    check("rst_state", state, 0);
    check("rst_desc_rst", desc_rst, 1);
    check("rst_locked", locked, 0);
    check("rst_err", err_cnt, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_bypass", desc_bypass, 0);

    // Release with good frames every cycle: SEED x2, FILL x4, lock on 8th good.
    rst_n = 1'b1;
    frame(1'b1, 0);
    step(1); check("seed1_state", state, 0); check("seed1_rst", desc_rst, 1);
    step(1); check("fill1_state", state, 1); check("fill1_rst", desc_rst, 1);
    step(1); check("fill2_state", state, 1); check("fill2_rst", desc_rst, 0);
    step(2); check("fill4_state", state, 1);
    step(1); check("hunt_state", state, 2);
    step(7); check("hunt7_state", state, 2); check("hunt7_locked", locked, 0);
    step(1); check("lock_state", state, 3); check("lock_locked", locked, 1);
    check("lock_err", err_cnt, 0);

    // Broken good run: 7 good, 1 bad, 8 good.
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    frame(1'b1, 0);
    step(6); check("run_hunt", state, 2);
    step(7);
    frame(1'b1, 1); step(1); check("run_bad_state", state, 2);
    frame(1'b1, 0); step(7); check("run_7good", locked, 0);
    step(1); check("run_8good", locked, 1); check("run_err", err_cnt, 0);

    // Locked: 3 bad, 1 good, 4 bad.
    frame(1'b1, 1); step(3);
    check("bad3_err", err_cnt, 3); check("bad3_state", state, 3);
    frame(1'b1, 0); step(1);
    frame(1'b1, 1); step(3);
    check("bad6_err", err_cnt, 6); check("bad6_state", state, 3);
    step(1);
    check("unlock_err", err_cnt, 7); check("unlock_state", state, 0);
    check("unlock_loss", loss_cnt, 1); check("unlock_locked", locked, 0);
    check("unlock_desc_rst", desc_rst, 0);
    lock_up("relock1");

    // Frame gap while locked.
    frame(1'b0, 0);
    step(255); check("gap255_state", state, 3);
    step(1); check("gap256_state", state, 0); check("gap_loss", loss_cnt, 2);

    // HUNT timeout with only bad frames.
    frame(1'b1, 1);
    step(6); check("to_hunt", state, 2);
    step(1023); check("to_1023", state, 2);
    step(1); check("to_seed", state, 0); check("to_loss", loss_cnt, 2);
    check("to_err", err_cnt, 7);
    lock_up("relock2");

    // relock_req with a same-cycle bad frame while locked.
    relock_req = 1'b1; frame(1'b1, 1); step(1); relock_req = 1'b0;
    check("rq_state", state, 0); check("rq_loss", loss_cnt, 3);
    check("rq_err", err_cnt, 8); check("rq_locked", locked, 0);
    lock_up("relock3");

    // err_clr beats a same-cycle bad frame.
    err_clr = 1'b1; frame(1'b1, 1); step(1); err_clr = 1'b0;
    check("clr_err", err_cnt, 0); check("clr_loss", loss_cnt, 0);
    check("clr_state", state, 3);

    // Saturation: preload err_cnt then one more bad frame.
    force dut.err_cnt = 16'hFFFF;
    #1;
    release dut.err_cnt;
    frame(1'b1, 1); step(1);
    check("sat_err", err_cnt, 16'hFFFF); check("sat_state", state, 3);
    frame(1'b1, 0);

    // Bypass follows with one cycle of latency; FSM unaffected.
    cfg_bypass = 1'b1;
    check("byp_before", desc_bypass, 0);
    step(1); check("byp_on", desc_bypass, 1); check("byp_state", state, 3);
    cfg_bypass = 1'b0;
    check("byp_hold", desc_bypass, 1);
    step(1); check("byp_off", desc_bypass, 0);

    // Reset while locked.
    rst_n = 1'b0; step(1);
    check("mrst_locked", locked, 0); check("mrst_state", state, 0);
    check("mrst_loss", loss_cnt, 0); check("mrst_desc_rst", desc_rst, 1);
    rst_n = 1'b1;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
